// File: rtl/serial_lut_loader.sv
// serial_lut_loader: shifts a WIDTH-bit LUT image out MSB-first on sd/sclk
// while scs_n is low. Every sclk phase lasts HALF_DIV clk cycles.
// Optional rotate burst (define LOADER_ROT_EN): rot_n goes low and
// rot_count sclk pulses are issued with scs_n held high.
// Every output is a register; no output is decoded from state.
module serial_lut_loader #(
  parameter int WIDTH    = 64,
  parameter int HALF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rot_start,
  input  logic [7:0]       rot_count,
  output logic             sd,
  output logic             sclk,
  output logic             scs_n,
  output logic             rot_n,
  output logic             busy,
  output logic             done
);

  localparam int CW  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BW0 = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Pulse counter also holds rot_count, so it is never narrower than 8 bits.
  localparam int PW  = (BW0 > 8) ? BW0 : 8;

`ifdef LOADER_ROT_EN
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, ROT_SETUP, ROT_HIGH, ROT_LOW, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;
  // Rotate inputs stay on the port list but do nothing in this build.
  logic unused_rot;
  assign unused_rot = rot_start ^ (^rot_count);
`endif

  state_t           state;
  logic [CW-1:0]    cnt;    // clk cycles spent in the current phase
  logic [PW-1:0]    pcnt;   // sclk pulses still to issue after the current one
  logic [WIDTH-1:0] shreg;  // MSB is the bit currently on sd
  logic             half_end;

  assign half_end = (cnt == CW'(HALF_DIV - 1));

  // Frame/burst sequencer; the phase counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pcnt  <= '0;
      shreg <= '0;
      sd    <= 1'b0;
      sclk  <= 1'b0;
      scs_n <= 1'b1;
      rot_n <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          busy <= 1'b0;
          // start has priority; rot_start in the same cycle is dropped
          if (start) begin
            shreg <= data_in;
            sd    <= data_in[WIDTH-1];
            pcnt  <= PW'(WIDTH - 1);
            sclk  <= 1'b0;
            scs_n <= 1'b0;
            busy  <= 1'b1;
            state <= SETUP;
          end
`ifdef LOADER_ROT_EN
          else if (rot_start) begin
            pcnt  <= PW'(rot_count);
            sclk  <= 1'b0;
            rot_n <= 1'b0;
            busy  <= 1'b1;
            state <= ROT_SETUP;
          end
`endif
        end
        SETUP: begin
          if (half_end) begin
            cnt   <= '0;
            sclk  <= 1'b1;
            state <= HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (half_end) begin
            // sd only moves on the falling edge, well clear of the sampling edge
            cnt   <= '0;
            sclk  <= 1'b0;
            sd    <= shreg[WIDTH-2];
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            state <= LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (half_end) begin
            cnt <= '0;
            if (pcnt == '0) begin
              scs_n <= 1'b1;
              sd    <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              pcnt  <= pcnt - 1'b1;
              sclk  <= 1'b1;
              state <= HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef LOADER_ROT_EN
        ROT_SETUP: begin
          if (half_end) begin
            cnt <= '0;
            // a zero-length burst finishes without any sclk edge
            if (pcnt == '0) begin
              rot_n <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              pcnt  <= pcnt - 1'b1;
              sclk  <= 1'b1;
              state <= ROT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ROT_HIGH: begin
          if (half_end) begin
            cnt   <= '0;
            sclk  <= 1'b0;
            state <= ROT_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ROT_LOW: begin
          if (half_end) begin
            cnt <= '0;
            if (pcnt == '0) begin
              rot_n <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              pcnt  <= pcnt - 1'b1;
              sclk  <= 1'b1;
              state <= ROT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        DONE: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_lut_loader.sv
// Directed bench for serial_lut_loader: a default 64-bit/HALF_DIV=2 instance
// and a 4-bit/HALF_DIV=1 instance share the clock and reset. The rotate
// checks adapt to whether LOADER_ROT_EN is defined.
module tb_serial_lut_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // default instance
  logic        start0 = 1'b0, rot_start0 = 1'b0;
  logic [63:0] data0 = '0;
  logic [7:0]  rot_count0 = '0;
  logic        sd0, sclk0, scs_n0, rot_n0, busy0, done0;

  // small instance
  logic        start1 = 1'b0, rot_start1 = 1'b0;
  logic [3:0]  data1 = '0;
  logic [7:0]  rot_count1 = '0;
  logic        sd1, sclk1, scs_n1, rot_n1, busy1, done1;

  serial_lut_loader dut0 (
    .clk(clk), .rst(rst), .start(start0), .data_in(data0),
    .rot_start(rot_start0), .rot_count(rot_count0),
    .sd(sd0), .sclk(sclk0), .scs_n(scs_n0), .rot_n(rot_n0),
    .busy(busy0), .done(done0)
  );

  serial_lut_loader #(.WIDTH(4), .HALF_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data1),
    .rot_start(rot_start1), .rot_count(rot_count1),
    .sd(sd1), .sclk(sclk1), .scs_n(scs_n1), .rot_n(rot_n1),
    .busy(busy1), .done(done1)
  );

  int nvec = 0;
  int nfail = 0;

  // monitor state (written only by the monitor)
  int          cyc = 0;
  int          rises0 = 0, rnocs0 = 0, rotlow0 = 0, busyc0 = 0, donec0 = 0;
  int          overlap0 = 0, badgap0 = 0, lastr0 = -1;
  logic [63:0] cap0 = '0;
  logic        psclk0 = 1'b0;
  int          rises1 = 0, busyc1 = 0, donec1 = 0, badgap1 = 0, lastr1 = -1;
  logic [3:0]  cap1 = '0;
  logic        psclk1 = 1'b0;

  // sample on the falling clk edge; a receiver sees sd at each sclk rise
  always @(negedge clk) begin
    cyc++;
    if (sclk0 === 1'b1 && psclk0 === 1'b0) begin
      cap0 = {cap0[62:0], sd0};
      rises0++;
      if (scs_n0 === 1'b1) rnocs0++;
      if (lastr0 >= 0 && cyc - lastr0 != 4) badgap0++;
      lastr0 = cyc;
    end
    if (busy0 !== 1'b1) lastr0 = -1;
    psclk0 = sclk0;
    if (busy0 === 1'b1) busyc0++;
    if (done0 === 1'b1) donec0++;
    if (rot_n0 === 1'b0) rotlow0++;
    if (scs_n0 === 1'b0 && rot_n0 === 1'b0) overlap0++;

    if (sclk1 === 1'b1 && psclk1 === 1'b0) begin
      cap1 = {cap1[2:0], sd1};
      rises1++;
      if (lastr1 >= 0 && cyc - lastr1 != 2) badgap1++;
      lastr1 = cyc;
    end
    if (busy1 !== 1'b1) lastr1 = -1;
    psclk1 = sclk1;
    if (busy1 === 1'b1) busyc1++;
    if (done1 === 1'b1) donec1++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle0();
    int k = 0;
    while (busy0 === 1'b1 && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle0_timeout", 64'(k < 5000), 64'd1);
  endtask

  // Called at posedge+1; returns at posedge+1 with the DUT idle.
  task automatic frame0(input logic [63:0] d, input int poke_at, input bit with_rot);
    int r, b, dn, ol, bg, rl, k;
    r = rises0; b = busyc0; dn = donec0; ol = overlap0; bg = badgap0; rl = rotlow0;
    data0 = d; start0 = 1'b1; rot_start0 = with_rot; rot_count0 = 8'd5;
    @(posedge clk); #1;
    start0 = 1'b0; rot_start0 = 1'b0;
    check("accept_busy", 64'(busy0), 64'd1);
    if (poke_at > 0) begin
      k = 0;
      while (rises0 - r < poke_at && k < 5000) begin
        @(posedge clk); #1;
        k++;
      end
      check("poke_timeout", 64'(k < 5000), 64'd1);
      data0 = '0; start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
    end
    wait_idle0();
    check("stream", cap0, d);
    check("rises", 64'(rises0 - r), 64'd64);
    check("busy_cycles", 64'(busyc0 - b), 64'd259);
    check("done_count", 64'(donec0 - dn), 64'd1);
    check("sclk_gap", 64'(badgap0 - bg), 64'd0);
    check("cs_rot_overlap", 64'(overlap0 - ol), 64'd0);
    check("rot_n_low", 64'(rotlow0 - rl), 64'd0);
  endtask

  task automatic frame1(input logic [3:0] d);
    int r, b, dn, bg, k;
    r = rises1; b = busyc1; dn = donec1; bg = badgap1;
    data1 = d; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    k = 0;
    while (busy1 === 1'b1 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle1_timeout", 64'(k < 1000), 64'd1);
    check("stream4", 64'(cap1), 64'(d));
    check("rises4", 64'(rises1 - r), 64'd4);
    check("busy4_cycles", 64'(busyc1 - b), 64'd10);
    check("done4_count", 64'(donec1 - dn), 64'd1);
    check("sclk4_gap", 64'(badgap1 - bg), 64'd0);
  endtask

  task automatic rot_burst(input logic [7:0] n);
    int r, rn, b, dn, rl, ol;
    r = rises0; rn = rnocs0; b = busyc0; dn = donec0; rl = rotlow0; ol = overlap0;
    rot_count0 = n; rot_start0 = 1'b1;
    @(posedge clk); #1;
    rot_start0 = 1'b0;
`ifdef LOADER_ROT_EN
    wait_idle0();
    check("rot_rises", 64'(rises0 - r), 64'(n));
    check("rot_rises_cs_high", 64'(rnocs0 - rn), 64'(n));
    check("rot_busy", 64'(busyc0 - b), 64'(2 * (2 * int'(n) + 1) + 1));
    check("rot_n_low_cycles", 64'(rotlow0 - rl), 64'(2 * (2 * int'(n) + 1)));
    check("rot_done", 64'(donec0 - dn), 64'd1);
`else
    repeat (10) @(posedge clk);
    #1;
    check("norot_rises", 64'(rises0 - r), 64'd0);
    check("norot_busy", 64'(busyc0 - b), 64'd0);
    check("norot_rot_n", 64'(rotlow0 - rl), 64'd0);
    check("norot_done", 64'(donec0 - dn), 64'd0);
`endif
    check("rot_overlap", 64'(overlap0 - ol), 64'd0);
  endtask

  typedef struct {
    logic [63:0] data;
    int          poke_at;
    bit          with_rot;
  } vec0_t;

  vec0_t      tv0[5];
  logic [3:0] tv1[4];

  initial begin
    int r, dn, k;
    tv0[0] = '{64'h9876543210FEDCBA, 0,  1'b0};
    tv0[1] = '{64'hFFFFFFFFFFFFFFFF, 0,  1'b0};
    tv0[2] = '{64'h0000000000000001, 0,  1'b0};
    tv0[3] = '{64'h9876543210FEDCBA, 20, 1'b0};
    tv0[4] = '{64'hA5A5_0F0F_3C3C_8001, 0, 1'b1};
    tv1[0] = 4'hA; tv1[1] = 4'h5; tv1[2] = 4'hF; tv1[3] = 4'h1;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sd",    64'(sd0),    64'd0);
    check("rst_sclk",  64'(sclk0),  64'd0);
    check("rst_scs_n", 64'(scs_n0), 64'd1);
    check("rst_rot_n", 64'(rot_n0), 64'd1);
    check("rst_busy",  64'(busy0),  64'd0);
    check("rst_done",  64'(done0),  64'd0);
    check("rst_busy4", 64'(busy1),  64'd0);
    // first start lands on the very first edge after reset release
    rst = 1'b0;

    for (int i = 0; i < 5; i++) frame0(tv0[i].data, tv0[i].poke_at, tv0[i].with_rot);

    // abort after the 10th sclk rise
    r = rises0; dn = donec0;
    data0 = 64'h0123456789ABCDEF; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    k = 0;
    while (rises0 - r < 10 && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort_timeout", 64'(k < 5000), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_scs_n", 64'(scs_n0), 64'd1);
    check("abort_sclk",  64'(sclk0),  64'd0);
    check("abort_busy",  64'(busy0),  64'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_rises", 64'(rises0 - r), 64'd10);
    check("abort_done",  64'(donec0 - dn), 64'd0);
    frame0(64'h9876543210FEDCBA, 0, 1'b0);

    rot_burst(8'd16);
    rot_burst(8'd0);

    for (int i = 0; i < 4; i++) frame1(tv1[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/serial_lut_loader.md
SERIAL_LUT_LOADER -- requirements
Module: serial_lut_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 64, number of LUT bits shifted per frame (≥2).
REQ-002 SHALL have parameter HALF_DIV, default 2, clk cycles per sclk half-period (≥1).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request one load frame.
REQ-006 SHALL have port data_in  input  WIDTH  LUT contents; bit WIDTH-1 sent first.
REQ-007 SHALL have port rot_start  input  1  request rotate burst (LOADER_ROT_EN only).
REQ-008 SHALL have port rot_count  input  8  sclk pulses in rotate burst.
REQ-009 SHALL have port sd  output  1  serial data to LUT d pin.
REQ-010 SHALL have port sclk  output  1  serial shift clock to LUT; receiver samples sd on rising edge.
REQ-011 SHALL have port scs_n  output  1  chip select, low during load frame.
REQ-012 SHALL have port rot_n  output  1  rotate enable, low during rotate burst.
REQ-013 SHALL have ports busy and done, output, 1 each: frame/burst in progress; one-cycle completion pulse.

Function
REQ-014 SHALL use FSM states IDLE, SETUP, HIGH, LOW, ROT_SETUP, ROT_HIGH, ROT_LOW, DONE; all outputs registered.
REQ-015 IDLE with start=1 SHALL latch data_in into shift register, enter SETUP; busy=1 from next cycle.
REQ-016 SETUP SHALL last HALF_DIV cycles with scs_n=0, sclk=0, sd=data bit WIDTH-1.
REQ-017 HIGH SHALL last HALF_DIV cycles with sclk=1, sd stable.
REQ-018 LOW SHALL last HALF_DIV cycles with sclk=0; sd SHALL advance to next bit on HIGH->LOW transition only.
REQ-019 After LOW of bit 0, FSM SHALL enter DONE: scs_n=1, sd=0, done=1 for exactly one cycle, busy=1; next cycle IDLE, busy=0.
REQ-020 Frame SHALL produce exactly WIDTH sclk rising edges; busy high for HALF_DIV*(2*WIDTH+1)+1 cycles (259 at defaults).
REQ-021 start or rot_start while busy=1 SHALL be ignored; data_in changes while busy SHALL NOT affect frame.
REQ-022 start and rot_start both high in IDLE: start SHALL win; rot_start dropped.
REQ-023 Half-period counter SHALL reset to 0 on every state change; no sclk glitch shorter than HALF_DIV cycles.
REQ-024 scs_n and rot_n SHALL never be low simultaneously.

Reset
REQ-025 rst=1 SHALL, on next clk edge, force IDLE, sd=0, sclk=0, scs_n=1, rot_n=1, busy=0, done=0, counters 0.
REQ-026 rst mid-frame or mid-burst SHALL abort with no further sclk edges; no done pulse issued.
REQ-027 First start SHALL be accepted in the cycle after rst deasserts.

Configuration
REQ-028 Macro LOADER_ROT_EN SHALL compile the rotate feature in or out.
REQ-029 With LOADER_ROT_EN: IDLE with rot_start=1 (start=0) SHALL latch rot_count, enter ROT_SETUP (rot_n=0, scs_n=1, sclk=0, HALF_DIV cycles), then rot_count HIGH/LOW pulse pairs, then DONE with rot_n=1.
REQ-030 With LOADER_ROT_EN and rot_count=0: ROT_SETUP SHALL go directly to DONE, zero sclk edges.
REQ-031 Without LOADER_ROT_EN: rot_start and rot_count ignored, rot_n constant 1, ROT_* states absent; ports retained.

Verification
REQ-032 Defaults, data_in=64'h9876543210FEDCBA, start pulse -> sd at 64 sclk rises = 1,0,0,1,1,0,0,0,... through ...1,0,1,0; scs_n low throughout; done 259 cycles after start.
REQ-033 start re-asserted at bit 20 with data_in=0 -> ignored; sampled stream unchanged; single done.
REQ-034 rst asserted after 10th sclk rise -> next cycle scs_n=1, sclk=0, busy=0; no done; new start then sends full 64 bits.
REQ-035 HALF_DIV=1, WIDTH=4, data_in=4'hA -> sd at rises 1,0,1,0; sclk period 2 cycles; busy 10 cycles.
REQ-036 LOADER_ROT_EN, rot_count=16 -> rot_n low, 16 sclk rises, scs_n high throughout; rot_count=0 -> zero rises, done once.
REQ-037 start and rot_start same cycle -> load frame only, rot_n stays 1.
